// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: per-side duty ramping with brake/dwell reversal
// for a two-channel H-bridge PWM controller write port.
module motor_ramp_sequencer #(
  parameter int TICK_DIV    = 1000000,
  parameter int STEP        = 5,
  parameter int DWELL_TICKS = 10
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_r_duty,
  input  logic        cmd_r_fwd,
  input  logic [6:0]  cmd_l_duty,
  input  logic        cmd_l_fwd,
  input  logic        estop,
  output logic [15:0] mc_wdata,
  output logic        mc_write,
  output logic        busy
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [7:0]    STEP8      = 8'(STEP);
  localparam logic [6:0]    DUTY_MAX   = 7'd100;

  typedef enum logic [1:0] {
    TRACK,
    BRAKE,
    DWELL
  } side_st_t;

  typedef struct packed {
    side_st_t      st;
    logic [DW-1:0] dw;
    logic          fwd;
    logic [6:0]    duty;
  } side_t;

  function automatic side_t idle_side(input logic fwd);
    side_t s;
    s.st   = TRACK;
    s.dw   = '0;
    s.fwd  = fwd;
    s.duty = 7'd0;
    return s;
  endfunction

  function automatic logic [6:0] ramp_to(
    input logic [6:0] cur,
    input logic [6:0] tgt
  );
    logic [7:0] c;
    logic [7:0] t;
    logic [6:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    r = tgt;
    if (t > c && (t - c) > STEP8)
      r = 7'(c + STEP8);
    else if (c > t && (c - t) > STEP8)
      r = 7'(c - STEP8);
    return r;
  endfunction

  function automatic logic [6:0] brake_dec(input logic [6:0] cur);
    logic [7:0] c;
    c = {1'b0, cur};
    return (c > STEP8) ? 7'(c - STEP8) : 7'd0;
  endfunction

  function automatic logic [6:0] clamp(input logic [6:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  // One tick of a side: a matching direction always resumes tracking,
  // a mismatch brakes to zero, dwells, then flips.
  function automatic side_t side_next(
    input side_t      s,
    input logic [6:0] td,
    input logic       tf
  );
    side_t      n;
    logic [6:0] b;
    n = s;
    b = brake_dec(s.duty);
    unique case (s.st)
      TRACK: begin
        if (tf == s.fwd) begin
          n.duty = ramp_to(s.duty, td);
        end else begin
          n.duty = b;
          n.dw   = '0;
          n.st   = (b == 7'd0) ? DWELL : BRAKE;
        end
      end
      BRAKE: begin
        if (tf == s.fwd) begin
          n.st   = TRACK;
          n.duty = ramp_to(s.duty, td);
        end else begin
          n.duty = b;
          if (b == 7'd0) begin
            n.st = DWELL;
            n.dw = '0;
          end
        end
      end
      DWELL: begin
        if (tf == s.fwd) begin
          n.st   = TRACK;
          n.dw   = '0;
          n.duty = ramp_to(s.duty, td);
        end else if (s.dw == DWELL_LAST) begin
          n.st  = TRACK;
          n.dw  = '0;
          n.fwd = tf;
        end else begin
          n.dw = s.dw + 1'b1;
        end
      end
      default: n.st = TRACK;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] pack(input side_t r, input side_t l);
    return {l.duty, r.duty, l.fwd, r.fwd};
  endfunction

  side_t         r_q;
  side_t         l_q;
  side_t         r_nx;
  side_t         l_nx;
  logic [6:0]    r_tgt;
  logic [6:0]    l_tgt;
  logic          r_tgt_fwd;
  logic          l_tgt_fwd;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   nx_word;
  logic [15:0]   stop_word;

  assign cmd_ready = ~estop;
  assign tick      = (tick_cnt == TICK_LAST);
  assign r_nx      = side_next(r_q, r_tgt, r_tgt_fwd);
  assign l_nx      = side_next(l_q, l_tgt, l_tgt_fwd);
  assign nx_word   = pack(r_nx, l_nx);
  assign stop_word = {7'd0, 7'd0, l_q.fwd, r_q.fwd};

  assign busy = (r_q.duty != r_tgt) || (r_q.fwd != r_tgt_fwd)
             || (r_q.st != TRACK)
             || (l_q.duty != l_tgt) || (l_q.fwd != l_tgt_fwd)
             || (l_q.st != TRACK);

  // Free-running ramp tick divider; estop restarts the tick period.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      tick_cnt <= '0;
    else if (estop || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // Target capture; estop parks targets at zero in the applied direction
  // so nothing moves after release until a fresh command.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tgt     <= 7'd0;
      l_tgt     <= 7'd0;
      r_tgt_fwd <= 1'b1;
      l_tgt_fwd <= 1'b1;
    end else if (estop) begin
      r_tgt     <= 7'd0;
      l_tgt     <= 7'd0;
      r_tgt_fwd <= r_q.fwd;
      l_tgt_fwd <= l_q.fwd;
    end else if (cmd_valid) begin
      r_tgt     <= clamp(cmd_r_duty);
      l_tgt     <= clamp(cmd_l_duty);
      r_tgt_fwd <= cmd_r_fwd;
      l_tgt_fwd <= cmd_l_fwd;
    end
  end

  // Side FSMs advance on tick; output word and strobe follow the change.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_q      <= idle_side(1'b1);
      l_q      <= idle_side(1'b1);
      mc_wdata <= 16'h0003;
      mc_write <= 1'b0;
    end else if (estop) begin
      r_q      <= idle_side(r_q.fwd);
      l_q      <= idle_side(l_q.fwd);
      mc_wdata <= stop_word;
      mc_write <= (stop_word != mc_wdata);
    end else if (tick) begin
      r_q      <= r_nx;
      l_q      <= l_nx;
      mc_wdata <= nx_word;
      mc_write <= (nx_word != mc_wdata);
    end else begin
      mc_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb_motor_ramp_sequencer: directed stimulus, per-cycle model compare
// plus literal strobe-sequence expectations.
`timescale 1ns/1ps
module tb_motor_ramp_sequencer;

  localparam int TD = 4;
  localparam int ST = 10;
  localparam int DT = 3;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_r_duty;
  logic        cmd_r_fwd;
  logic [6:0]  cmd_l_duty;
  logic        cmd_l_fwd;
  logic        estop;
  logic [15:0] mc_wdata;
  logic        mc_write;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_duty[2];
  int m_tgt[2];
  int m_dleft[2];
  int m_cnt;
  bit m_fwd[2];
  bit m_tfwd[2];
  bit m_rev[2];
  bit m_write;

  logic [15:0] log_w[$];
  int          log_c[$];

  int r3[9] = '{25, 15, 5, 0, 0, 10, 20, 30, 35};
  bit f3[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  int r6[6] = '{20, 10, 0, 10, 20, 30};

  motor_ramp_sequencer #(
    .TICK_DIV(TD),
    .STEP(ST),
    .DWELL_TICKS(DT)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_r_duty(cmd_r_duty),
    .cmd_r_fwd(cmd_r_fwd),
    .cmd_l_duty(cmd_l_duty),
    .cmd_l_fwd(cmd_l_fwd),
    .estop(estop),
    .mc_wdata(mc_wdata),
    .mc_write(mc_write),
    .busy(busy)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] w(input int ld, input int rd,
                                    input bit lf, input bit rf);
    return {7'(ld), 7'(rd), lf, rf};
  endfunction

  function automatic logic [15:0] m_word();
    return w(m_duty[1], m_duty[0], m_fwd[1], m_fwd[0]);
  endfunction

  function automatic bit m_busy();
    bit b;
    b = 1'b0;
    for (int s = 0; s < 2; s++)
      if (m_duty[s] != m_tgt[s] || m_fwd[s] != m_tfwd[s] || m_rev[s])
        b = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      m_duty[s]  = 0;
      m_tgt[s]   = 0;
      m_fwd[s]   = 1'b1;
      m_tfwd[s]  = 1'b1;
      m_rev[s]   = 1'b0;
      m_dleft[s] = 0;
    end
    m_cnt   = 0;
    m_write = 1'b0;
  endtask

  // One tick for one side: m_dleft counts the zero-duty ticks still
  // owed before the direction may flip (0 = still braking).
  task automatic m_side(input int s);
    if (m_tfwd[s] == m_fwd[s]) begin
      m_rev[s]   = 1'b0;
      m_dleft[s] = 0;
      if (m_duty[s] < m_tgt[s])
        m_duty[s] = (m_tgt[s] - m_duty[s] > ST) ? m_duty[s] + ST : m_tgt[s];
      else
        m_duty[s] = (m_duty[s] - m_tgt[s] > ST) ? m_duty[s] - ST : m_tgt[s];
    end else begin
      m_rev[s] = 1'b1;
      if (m_dleft[s] == 0) begin
        m_duty[s] = (m_duty[s] > ST) ? m_duty[s] - ST : 0;
        if (m_duty[s] == 0) m_dleft[s] = DT;
      end else begin
        m_dleft[s]--;
        if (m_dleft[s] == 0) begin
          m_fwd[s] = m_tfwd[s];
          m_rev[s] = 1'b0;
        end
      end
    end
  endtask

  task automatic m_step();
    logic [15:0] old;
    bit          tk;
    old = m_word();
    if (estop) begin
      for (int s = 0; s < 2; s++) begin
        m_duty[s]  = 0;
        m_tgt[s]   = 0;
        m_tfwd[s]  = m_fwd[s];
        m_rev[s]   = 1'b0;
        m_dleft[s] = 0;
      end
      m_cnt   = 0;
      m_write = (m_word() != old);
    end else begin
      tk = (m_cnt == TD - 1);
      if (tk) begin
        m_side(0);
        m_side(1);
      end
      m_write = tk && (m_word() != old);
      m_cnt   = tk ? 0 : m_cnt + 1;
      if (cmd_valid) begin
        m_tgt[0]  = (cmd_r_duty > 7'd100) ? 100 : int'(cmd_r_duty);
        m_tgt[1]  = (cmd_l_duty > 7'd100) ? 100 : int'(cmd_l_duty);
        m_tfwd[0] = cmd_r_fwd;
        m_tfwd[1] = cmd_l_fwd;
      end
    end
  endtask

  // Per-cycle compare against the model, strobe logging, model advance.
  initial begin
    forever begin
      @(negedge PCLK);
      cyc++;
      if (PRESET) m_reset();
      chk("mc_wdata", 32'(mc_wdata), 32'(m_word()));
      chk("mc_write", 32'(mc_write), 32'(m_write));
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("cmd_ready", 32'(cmd_ready), 32'(!estop));
      if (mc_write) begin
        log_w.push_back(mc_wdata);
        log_c.push_back(cyc);
      end
      if (!PRESET) m_step();
    end
  end

  task automatic send(input int rd, input bit rf, input int ld, input bit lf);
    @(posedge PCLK);
    #1;
    cmd_valid  = 1'b1;
    cmd_r_duty = 7'(rd);
    cmd_r_fwd  = rf;
    cmd_l_duty = 7'(ld);
    cmd_l_fwd  = lf;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge PCLK);
    #1 PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge PCLK);
    #1;
  endtask

  task automatic wait_r(input int d, input int budget);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge PCLK);
      hit = mc_write && (mc_wdata[8:2] == 7'(d));
      n++;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_r duty %0d not strobed in %0d cycles", d, budget);
    end
  endtask

  task automatic log_at(input int i, input logic [15:0] e);
    logic [31:0] a;
    a = (i < log_w.size()) ? 32'(log_w[i]) : 32'hFFFF_FFFF;
    chk($sformatf("strobe%0d", i), a, 32'(e));
  endtask

  initial begin
    int mx;
    PRESET     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_r_duty = 7'd0;
    cmd_r_fwd  = 1'b1;
    cmd_l_duty = 7'd0;
    cmd_l_fwd  = 1'b1;
    estop      = 1'b0;
    #2 PRESET  = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // reset state
    settle(1);
    chk("rst_wdata", 32'(mc_wdata), 32'h0003);
    chk("rst_write", 32'(mc_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // forward ramp to 35
    log_w.delete();
    log_c.delete();
    send(35, 1'b1, 0, 1'b1);
    settle(30);
    chk("t2_count", 32'(log_w.size()), 32'd4);
    for (int i = 0; i < 4; i++) log_at(i, w(0, 10 * (i + 1) - ((i == 3) ? 5 : 0), 1'b1, 1'b1));
    if (log_c.size() >= 4)
      for (int i = 0; i < 3; i++)
        chk("t2_gap", 32'(log_c[i + 1] - log_c[i]), 32'd4);
    chk("t2_busy", 32'(busy), 32'd0);

    // reversal with brake and dwell
    log_w.delete();
    log_c.delete();
    send(35, 1'b0, 0, 1'b1);
    settle(70);
    chk("t3_count", 32'(log_w.size()), 32'd9);
    for (int i = 0; i < 9; i++) log_at(i, w(0, r3[i], 1'b1, f3[i]));
    if (log_c.size() >= 5)
      chk("t3_dwell_gap", 32'(log_c[4] - log_c[3]), 32'd12);

    // left clamp at 100
    log_w.delete();
    log_c.delete();
    send(35, 1'b0, 120, 1'b1);
    settle(60);
    chk("t4_count", 32'(log_w.size()), 32'd10);
    for (int i = 0; i < 10; i++) log_at(i, w(10 * (i + 1), 35, 1'b1, 1'b0));
    mx = 0;
    foreach (log_w[i])
      if (int'(log_w[i][15:9]) > mx) mx = int'(log_w[i][15:9]);
    chk("t4_lmax", 32'(mx), 32'd100);
    chk("t4_lduty", 32'(mc_wdata[15:9]), 32'd100);

    // estop mid-ramp
    do_reset();
    log_w.delete();
    log_c.delete();
    send(60, 1'b1, 0, 1'b1);
    wait_r(20, 40);
    @(posedge PCLK);
    #1;
    estop      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_r_duty = 7'd90;
    cmd_r_fwd  = 1'b1;
    #1 chk("t5_ready", 32'(cmd_ready), 32'd0);
    @(posedge PCLK);
    #1;
    chk("t5_write", 32'(mc_write), 32'd1);
    chk("t5_wdata", 32'(mc_wdata), 32'h0003);
    repeat (5) @(posedge PCLK);
    #1;
    estop     = 1'b0;
    cmd_valid = 1'b0;
    settle(20);
    chk("t5_hold", 32'(mc_wdata), 32'h0003);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(log_w.size()), 32'd3);
    log_at(1, w(0, 20, 1'b1, 1'b1));
    log_at(2, 16'h0003);

    // reversal abandoned during dwell, then reset mid-ramp
    do_reset();
    send(30, 1'b1, 0, 1'b1);
    settle(25);
    log_w.delete();
    log_c.delete();
    send(30, 1'b0, 0, 1'b1);
    wait_r(0, 40);
    send(30, 1'b1, 0, 1'b1);
    settle(30);
    chk("t6_count", 32'(log_w.size()), 32'd6);
    for (int i = 0; i < 6; i++) log_at(i, w(0, r6[i], 1'b1, 1'b1));
    send(60, 1'b1, 0, 1'b1);
    wait_r(40, 30);
    @(posedge PCLK);
    #1 PRESET = 1'b1;
    #1;
    chk("t6_rst_wdata", 32'(mc_wdata), 32'h0003);
    chk("t6_rst_write", 32'(mc_write), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    settle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
